// File: rtl/hazard_controller_if.sv
// hazard_controller_if: D/E-stage hazard information from the datapath and
// the hold/flush/forward controls returned to it.
interface hazard_controller_if;
  logic [3:0] srcAdd1;
  logic [3:0] srcAdd2;
  logic       immediateC;
  logic       InstBranch;
  logic       RegWriteE;
  logic       MemToRegE;
  logic [3:0] destAddE;
  logic       stallF;
  logic       stallD;
  logic       flushD;
  logic       flushC;
  logic       forwardA;
  logic       forwardB;
  logic [1:0] hz_state;

  // Datapath / control-unit side
  modport master (
    output srcAdd1, srcAdd2, immediateC, InstBranch, RegWriteE, MemToRegE, destAddE,
    input  stallF, stallD, flushD, flushC, forwardA, forwardB, hz_state
  );

  // Hazard controller side
  modport slave (
    input  srcAdd1, srcAdd2, immediateC, InstBranch, RegWriteE, MemToRegE, destAddE,
    output stallF, stallD, flushD, flushC, forwardA, forwardB, hz_state
  );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: stall, flush and E-to-D forwarding control for the
// 5-stage 16-bit CPU. Destinations of the M and W stages are tracked in
// shadow registers because the datapath only exposes E-stage information.
// Define HAZARD_PERF_EN to add saturating stall/flush event counters.
module hazard_controller #(
  parameter int unsigned REGFILE_BYPASS     = 0,
  parameter int unsigned ZERO_REG_HARDWIRED = 0,
  parameter int unsigned PERF_W             = 16
) (
  input  logic              clk,
  input  logic              reset,
  hazard_controller_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  // With write-through the W-stage result is already visible to D.
  localparam bit CheckW   = (REGFILE_BYPASS == 0);
  localparam bit ZeroMask = (ZERO_REG_HARDWIRED != 0);

  localparam logic [1:0] HzRun   = 2'd0;
  localparam logic [1:0] HzStall = 2'd1;
  localparam logic [1:0] HzFlush = 2'd2;

  logic       wrM;
  logic       wrW;
  logic [3:0] dstM;
  logic [3:0] dstW;
  logic       dValid;
  logic       dValidNext;
  logic [1:0] hzStateReg;
  logic [1:0] hzStateNext;

  logic [3:0] srcAddr [2];
  logic [1:0] srcChecked;
  logic [1:0] srcFwd;
  logic [1:0] srcStall;
  logic       stall;
  logic       branchFlush;

  assign srcAddr[0] = hz.srcAdd1;
  assign srcAddr[1] = hz.srcAdd2;

  // An empty decode slot never depends on anything; src2 is unused by immediates.
  assign srcChecked = {dValid & ~hz.immediateC, dValid};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gSrc
      logic isZero;
      logic hitE;
      logic hitM;
      logic hitW;

      assign isZero = ZeroMask && (srcAddr[gi] == 4'd0);
      assign hitE   = srcChecked[gi] & ~isZero & hz.RegWriteE & (hz.destAddE == srcAddr[gi]);
      assign hitM   = srcChecked[gi] & ~isZero & wrM & (dstM == srcAddr[gi]);
      assign hitW   = srcChecked[gi] & ~isZero & CheckW & wrW & (dstW == srcAddr[gi]);

      // E holds the newest value, so an E hit shadows any older M/W hit.
      assign srcFwd[gi]   = hitE & ~hz.MemToRegE;
      assign srcStall[gi] = (hitE & hz.MemToRegE) | (~hitE & (hitM | hitW));
    end
  endgenerate

  assign stall = |srcStall;
  // A stall holds the PC, so a pending branch is simply re-evaluated later.
  assign branchFlush = ~stall & hz.InstBranch & dValid;

  // State register: shadow pipeline, decode-slot validity and last action
  always_ff @(posedge clk) begin
    if (reset) begin
      wrM        <= 1'b0;
      dstM       <= 4'd0;
      wrW        <= 1'b0;
      dstW       <= 4'd0;
      dValid     <= 1'b0;
      hzStateReg <= HzRun;
    end else begin
      wrM        <= hz.RegWriteE;
      dstM       <= hz.destAddE;
      wrW        <= wrM;
      dstW       <= dstM;
      dValid     <= dValidNext;
      hzStateReg <= hzStateNext;
    end
  end

  // Next-state: decode slot empties on flush, fills whenever decode loads
  always_comb begin
    dValidNext = dValid;
    if (branchFlush) begin
      dValidNext = 1'b0;
    end else if (!stall) begin
      dValidNext = 1'b1;
    end
    hzStateNext = HzRun;
    if (stall) begin
      hzStateNext = HzStall;
    end else if (branchFlush) begin
      hzStateNext = HzFlush;
    end
  end

  // Outputs: reset forces a clean pipeline, stall beats branch
  always_comb begin
    hz.stallF   = 1'b1;
    hz.stallD   = 1'b1;
    hz.flushD   = 1'b0;
    hz.flushC   = 1'b0;
    hz.forwardA = 1'b0;
    hz.forwardB = 1'b0;
    hz.hz_state = hzStateReg;
    if (reset) begin
      hz.flushD = 1'b1;
      hz.flushC = 1'b1;
    end else if (stall) begin
      hz.stallF = 1'b0;
      hz.stallD = 1'b0;
      hz.flushC = 1'b1;
    end else begin
      hz.flushD   = branchFlush;
      hz.forwardA = srcFwd[0];
      hz.forwardB = srcFwd[1];
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [PERF_W-1:0] PerfOne = 1;

  // Saturating stall/flush event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + PerfOne;
      end
      if (branchFlush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + PerfOne;
      end
    end
  end
`else
  // Counters are not built; the control behaviour is unchanged.
`endif

endmodule
